// File: rtl/hack_mem_pkg.sv
// rtl/hack_mem_pkg.sv - shared RAM geometry constants and loader state type
// Purpose: constants describing the 16K-word RAM and the loader FSM states.
// Ports: none (package).
package hack_mem_pkg;

  localparam int RAM_ADDR_W = 14;
  localparam int RAM_DATA_W = 16;
  localparam int RAM_DEPTH  = 16384;
  // Word counts range 0..RAM_DEPTH inclusive, so one bit wider than the address.
  localparam int COUNT_W    = RAM_ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RECV_HI = 3'd1,
    S_RECV_LO = 3'd2,
    S_WRITE   = 3'd3,
    S_VERIFY  = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6
  } loader_state_e;

endpackage

// File: rtl/ram16k_loader_if.sv
// rtl/ram16k_loader_if.sv - host control, byte stream and RAM port bundle for the loader
// Purpose: groups every loader-facing signal except clk/reset.
// Ports (master = loader side):
//   in : start, base_addr, word_count, byte_in, byte_valid, ram_out
//   out: byte_ready, ram_load, ram_address, ram_in, busy, done, error, checksum
interface ram16k_loader_if;
  import hack_mem_pkg::*;

  logic                  start;
  logic [RAM_ADDR_W-1:0] base_addr;
  logic [COUNT_W-1:0]    word_count;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  ram_load;
  logic [RAM_ADDR_W-1:0] ram_address;
  logic [RAM_DATA_W-1:0] ram_in;
  logic [RAM_DATA_W-1:0] ram_out;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [RAM_DATA_W-1:0] checksum;

  modport master (
    input  start, base_addr, word_count, byte_in, byte_valid, ram_out,
    output byte_ready, ram_load, ram_address, ram_in, busy, done, error, checksum
  );

  modport slave (
    output start, base_addr, word_count, byte_in, byte_valid, ram_out,
    input  byte_ready, ram_load, ram_address, ram_in, busy, done, error, checksum
  );

endinterface

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - big-endian byte pair to word packer
// Purpose: runs the byte handshake while the loader is in RECV_HI/RECV_LO and
//   assembles {hi, lo} into a word register that holds until the next word.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   recv_hi_i, recv_lo_i  loader is waiting for the high / low byte
//   byte_i, byte_valid_i  incoming stream byte
//   byte_ready_o          byte accepted this cycle when byte_valid_i is high
//   word_valid_o          low byte accepted this cycle; word_o updates at the edge
//   word_o                last completed word
module byte_word_packer #(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                recv_hi_i,
  input  logic                recv_lo_i,
  input  logic [DATA_W/2-1:0] byte_i,
  input  logic                byte_valid_i,
  output logic                byte_ready_o,
  output logic                word_valid_o,
  output logic [DATA_W-1:0]   word_o
);

  localparam int BYTE_W = DATA_W / 2;

  logic [BYTE_W-1:0] hi_q;
  logic [DATA_W-1:0] word_q;

  assign byte_ready_o = recv_hi_i | recv_lo_i;
  assign word_valid_o = recv_lo_i & byte_valid_i;
  assign word_o       = word_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      word_q <= '0;
    end else begin
      if (recv_hi_i && byte_valid_i) begin
        hi_q <= byte_i;
      end
      // The word register doubles as the RAM write-data register, so it must
      // only change when a full pair has arrived.
      if (word_valid_o) begin
        word_q <= {hi_q, byte_i};
      end
    end
  end

endmodule

// File: rtl/ram16k_loader.sv
// rtl/ram16k_loader.sv - byte-stream program loader with readback checksum verify
// Purpose: writes big-endian byte pairs to consecutive RAM words from a base
//   address, re-reads the range and compares additive checksums.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset, aborts any transfer
//   bus    ram16k_loader_if.master: host control, byte stream, RAM port, status
module ram16k_loader
  import hack_mem_pkg::*;
#(
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int DATA_W    = RAM_DATA_W,
  parameter int MAX_WORDS = RAM_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  ram16k_loader_if.master bus
);

  loader_state_e      state_q;
  logic [ADDR_W-1:0]  ptr_q;
  logic [ADDR_W-1:0]  base_q;
  logic [COUNT_W-1:0] rem_q;
  logic [COUNT_W-1:0] count_q;
  logic [DATA_W-1:0]  wsum_q;
  logic [DATA_W-1:0]  rsum_q;
  logic [DATA_W-1:0]  checksum_q;
  logic               error_q;
  logic               busy_q;
  logic               done_q;
  logic               ram_load_q;

  logic [COUNT_W-1:0] count_clamped;
  logic               recv_hi;
  logic               recv_lo;
  logic               word_valid;
  logic [DATA_W-1:0]  word;

  assign count_clamped = (bus.word_count > COUNT_W'(MAX_WORDS)) ? COUNT_W'(MAX_WORDS)
                                                                 : bus.word_count;
  assign recv_hi = (state_q == S_RECV_HI);
  assign recv_lo = (state_q == S_RECV_LO);

  byte_word_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk          (clk),
    .reset        (reset),
    .recv_hi_i    (recv_hi),
    .recv_lo_i    (recv_lo),
    .byte_i       (bus.byte_in),
    .byte_valid_i (bus.byte_valid),
    .byte_ready_o (bus.byte_ready),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // The packed word register is held between writes, which gives ram_in its
  // hold-last-value behaviour for free. ptr_q is the address in every state.
  assign bus.ram_load    = ram_load_q;
  assign bus.ram_address = ptr_q;
  assign bus.ram_in      = word;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.checksum    = checksum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      base_q     <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      wsum_q     <= '0;
      rsum_q     <= '0;
      checksum_q <= '0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ram_load_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      ram_load_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            ptr_q      <= bus.base_addr;
            base_q     <= bus.base_addr;
            rem_q      <= count_clamped;
            count_q    <= count_clamped;
            wsum_q     <= '0;
            rsum_q     <= '0;
            checksum_q <= '0;
            error_q    <= 1'b0;
            if (count_clamped == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RECV_HI;
              busy_q  <= 1'b1;
            end
          end
        end

        S_RECV_HI: begin
          if (bus.byte_valid) begin
            state_q <= S_RECV_LO;
          end
        end

        S_RECV_LO: begin
          if (word_valid) begin
            state_q    <= S_WRITE;
            ram_load_q <= 1'b1;
          end
        end

        S_WRITE: begin
          wsum_q <= wsum_q + word;
          if (rem_q == COUNT_W'(1)) begin
            // Last word written: rewind to the start for the readback pass.
            ptr_q   <= base_q;
            rem_q   <= count_q;
            state_q <= S_VERIFY;
          end else begin
            ptr_q   <= ptr_q + ADDR_W'(1);
            rem_q   <= rem_q - COUNT_W'(1);
            state_q <= S_RECV_HI;
          end
        end

        S_VERIFY: begin
          rsum_q <= rsum_q + bus.ram_out;
          ptr_q  <= ptr_q + ADDR_W'(1);
          rem_q  <= rem_q - COUNT_W'(1);
          if (rem_q == COUNT_W'(1)) begin
            state_q <= S_CHECK;
          end
        end

        S_CHECK: begin
          error_q    <= (rsum_q != wsum_q);
          checksum_q <= wsum_q;
          state_q    <= S_DONE;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram16k_loader.sv
// tb/tb_ram16k_loader.sv - scoreboard bench for ram16k_loader with a RAM16K model
module tb_ram16k_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   start_cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram16k_loader_if bus();

  ram16k_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM16K model: synchronous write, combinational read, optional single-bit
  // corruption of one address on the read path.
  logic [15:0] mem [0:16383];
  logic        corrupt_en = 1'b0;
  logic [13:0] corrupt_addr = '0;

  always @(posedge clk) if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
  assign bus.ram_out = mem[bus.ram_address] ^
                       ((corrupt_en && bus.ram_address == corrupt_addr) ? 16'h0001 : 16'h0000);

  typedef struct { int addr; logic [15:0] data; int cyc; } wr_t;
  typedef struct { logic [15:0] cs; logic err; int cyc; } dn_t;
  wr_t wq[$];
  dn_t dq[$];
  wr_t mw;
  dn_t md;

  logic [7:0] tx[$];
  int         wcyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes RAM or pulses done.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ram_load) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual=addr %0h expected=no write", bus.ram_address);
        end else begin
          mw = wq.pop_front();
          chk("write_addr", 32'(bus.ram_address), 32'(mw.addr));
          chk("write_data", 32'(bus.ram_in), 32'(mw.data));
          chk("write_cycle", 32'(cyc - start_cyc), 32'(mw.cyc));
          chk("ready_in_write", 32'(bus.byte_ready), 32'd0);
        end
      end
      if (bus.done) begin
        if (dq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          md = dq.pop_front();
          chk("checksum", 32'(bus.checksum), 32'(md.cs));
          chk("error", 32'(bus.error), 32'(md.err));
          chk("done_cycle", 32'(cyc - start_cyc), 32'(md.cyc));
          chk("busy_at_done", 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  task automatic run_load(input int base, input int count, input int stall_idx,
                          input int stall_len, input int poke_idx,
                          input logic [15:0] exp_cs, input logic exp_err, input int exp_done);
    int t;
    for (int k = 0; k < count; k++)
      wq.push_back('{addr: (base + k) % 16384, data: {tx[2*k], tx[2*k+1]}, cyc: wcyc[k]});
    dq.push_back('{cs: exp_cs, err: exp_err, cyc: exp_done});
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = 14'(base);
    bus.word_count = 15'(count);
    start_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < tx.size(); i++) begin
      if (i == stall_idx) begin
        bus.byte_valid = 1'b0;
        repeat (stall_len) @(negedge clk);
      end
      bus.byte_in = tx[i];
      bus.byte_valid = 1'b1;
      if (i == poke_idx) begin
        bus.start = 1'b1;
        bus.base_addr = 14'd200;
        bus.word_count = 15'd5;
      end
      t = 0;
      while (!bus.byte_ready && t < 50) begin
        @(negedge clk);
        bus.start = 1'b0;
        t++;
      end
      if (t >= 50) begin
        checks++; failures++;
        $display("FAIL byte_accept_timeout actual=ready 0 expected=ready 1");
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.byte_valid = 1'b0;
    t = 0;
    while ((dq.size() != 0 || wq.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=pending %0d expected=0", dq.size() + wq.size());
      dq.delete();
      wq.delete();
    end
    repeat (2) @(negedge clk);
    chk("busy_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.word_count = '0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_ram_load", 32'(bus.ram_load), 32'd0);
    chk("rst_ram_address", 32'(bus.ram_address), 32'd0);
    chk("rst_ram_in", 32'(bus.ram_in), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_checksum", 32'(bus.checksum), 32'd0);

    // 1: basic two-word load at address 0
    tx = '{8'hA0, 8'h00, 8'hB1, 8'h11};
    wcyc = '{3, 6};
    run_load(0, 2, -1, 0, -1, 16'h5111, 1'b0, 10);
    chk("t1_ram0", 32'(mem[0]), 32'h0000A000);
    chk("t1_ram1", 32'(mem[1]), 32'h0000B111);

    // 2: address wrap from 16383 to 0
    tx = '{8'hDF, 8'hFF, 8'h12, 8'h34};
    wcyc = '{3, 6};
    run_load(16383, 2, -1, 0, -1, 16'hF233, 1'b0, 10);
    chk("t2_ram16383", 32'(mem[16383]), 32'h0000DFFF);
    chk("t2_ram0", 32'(mem[0]), 32'h00001234);

    // 3: four-cycle stall between the bytes of word 2
    tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    wcyc = '{3, 10, 13};
    run_load(50, 3, 3, 4, -1, 16'h090C, 1'b0, 18);
    chk("t3_ram50", 32'(mem[50]), 32'h00000102);
    chk("t3_ram51", 32'(mem[51]), 32'h00000304);
    chk("t3_ram52", 32'(mem[52]), 32'h00000506);

    // 4: zero-length load, then a start pulse while busy must be ignored
    tx = {};
    wcyc = {};
    run_load(7, 0, -1, 0, -1, 16'h0000, 1'b0, 1);
    tx = '{8'h12, 8'h34};
    wcyc = '{3};
    mem[200] = 16'hCAFE;
    run_load(100, 1, -1, 0, 1, 16'h1234, 1'b0, 6);
    chk("t4_ram100", 32'(mem[100]), 32'h00001234);
    chk("t4_ram200", 32'(mem[200]), 32'h0000CAFE);

    // 5: corrupted readback of one address
    corrupt_addr = 14'd301;
    corrupt_en = 1'b1;
    tx = '{8'h00, 8'h10, 8'h00, 8'h20};
    wcyc = '{3, 6};
    run_load(300, 2, -1, 0, -1, 16'h0030, 1'b1, 10);
    corrupt_en = 1'b0;

    // 6: reset right after the first write aborts the load
    tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    wq.push_back('{addr: 1000, data: 16'h1122, cyc: 3});
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = 14'd1000;
    bus.word_count = 15'd4;
    start_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.byte_in = 8'h11;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_in = 8'h22;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_ram_load", 32'(bus.ram_load), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_byte_ready", 32'(bus.byte_ready), 32'd0);
    repeat (20) @(negedge clk);
    chk("t6_pending_writes", 32'(wq.size()), 32'd0);
    chk("t6_ram1000", 32'(mem[1000]), 32'h00001122);
    wcyc = '{3, 6, 9, 12};
    run_load(1000, 4, -1, 0, -1, 16'h1154, 1'b0, 18);
    chk("t6_ram1003", 32'(mem[1003]), 32'h00007788);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/ram16k_loader.md
Name: ram16k_loader

Overview:
Boot/program loader that sits directly upstream of the 16K-word RAM and drives its load/address/in port. It accepts a byte stream (big-endian pairs) over a valid/ready handshake and writes each 16-bit word to consecutive RAM addresses from a programmable base. It then re-reads the written range through the RAM's out port and compares a 16-bit additive checksum of the readback against the written data. It reports done and error flags to the host.

Parameters:
ADDR_W, 14, RAM address width (16384 words)
DATA_W, 16, RAM word width; fixed at 2 bytes per word
MAX_WORDS, 16384, largest transfer length; larger word_count values are clamped to this

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a load; sampled only in IDLE
base_addr  in  14  first RAM address, captured on start
word_count  in  15  number of words to load, captured on start
byte_in  in  8  stream data byte
byte_valid  in  1  byte_in is valid
byte_ready  out  1  loader accepts byte_in this cycle
ram_load  out  1  RAM write enable
ram_address  out  14  RAM address
ram_in  out  16  RAM write data
ram_out  in  16  RAM read data (combinational from ram_address)
busy  out  1  high in RECV_HI..CHECK
done  out  1  one-cycle pulse at end of transfer
error  out  1  readback checksum mismatch; held until next start
checksum  out  16  sum mod 2^16 of written words; held until next start

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; internal pointer, remaining count, and both sums cleared. Reset during any state aborts the transfer. ram_load is 0 from the next cycle. RAM contents already written are left as is.
- IDLE: byte_ready=0, ram_load=0.
  - On start: capture base_addr into ptr and min(word_count, MAX_WORDS) into rem; clear sums and error.
  - If rem==0, go to DONE; else go to RECV_HI.
  - start outside IDLE is ignored.
- RECV_HI: byte_ready=1. On byte_valid, latch hi=byte_in and go to RECV_LO. Otherwise hold.
- RECV_LO: byte_ready=1. On byte_valid, latch lo=byte_in and go to WRITE.
- WRITE (exactly one cycle): byte_ready=0, ram_load=1, ram_address=ptr, ram_in={hi,lo}.
  - Update wsum+= {hi,lo} (mod 2^16), rem-=1, ptr+=1 (mod 2^14, so 16383 wraps to 0).
  - If the new rem==0, reload ptr=base and rem=count, then go to VERIFY. Otherwise go to RECV_HI.
- VERIFY: ram_load=0, ram_address=ptr. Each cycle: rsum+=ram_out, ptr+=1 with wrap, rem-=1. When rem reaches 0, go to CHECK.
- CHECK (one cycle): error<=(rsum!=wsum); checksum<=wsum; go to DONE.
- DONE (one cycle): done=1, busy=0; go to IDLE. A start arriving in DONE is ignored.
- Outside WRITE, ram_load=0 and ram_in holds its last value. Outside VERIFY and WRITE, ram_address holds ptr.
- Latency with byte_valid held high, start sampled in cycle 0:
  - WRITE of word k (k=1..N) falls in cycle 3k.
  - VERIFY occupies cycles 3N+1..4N; CHECK is cycle 4N+1; done pulses in cycle 4N+2.
  - For N=0, done pulses in cycle 1.
- Each stall cycle with byte_valid=0 adds one cycle per occurrence; the loader never drops or duplicates a byte.
- All arithmetic is unsigned and truncated to 16 bits. A wrapping transfer (base+N>16384) continues at address 0.

Decomposition:
- Package hack_mem_pkg holds the shared constants and state type:
  - RAM_ADDR_W=14, RAM_DATA_W=16, RAM_DEPTH=16384;
  - the loader state enum (IDLE, RECV_HI, RECV_LO, WRITE, VERIFY, CHECK, DONE).
- One natural sub-module, byte_word_packer: the RECV_HI/RECV_LO handshake and hi/lo byte registers, producing a word_valid pulse.
- The top level keeps the FSM, pointers, and checksums, and instantiates the existing RAM16K in the bench only.

Test Plan:
1. base=0, count=2, bytes A0 00 B1 11 sent back-to-back -> RAM[0]=A000 and RAM[1]=B111; ram_load high in cycles 3 and 6; done in cycle 10; checksum=5111; error=0.
2. base=16383, count=2, bytes DF FF 12 34 -> RAM[16383]=DFFF and RAM[0]=1234 (wrap); checksum=F233; error=0.
3. count=3 with byte_valid dropped for 4 cycles between the two bytes of word 2 -> RAM[base..base+2] correct; done delayed by exactly 4 cycles vs. the no-stall run; byte_ready=0 during WRITE.
4. count=0 start -> done in cycle 1; no ram_load; checksum=0; error=0. A second start issued during busy is ignored.
5. Bench model corrupts ram_out for one VERIFY address (XOR 0001) -> error=1 at done; checksum still equals the written sum.
6. reset asserted in the cycle after the first WRITE of a 4-word load -> ram_load=0, busy=0, done never pulses, RAM[base]=first word. A new start then completes a full load normally.
